// File: rtl/pc_fetch_if.sv
// pc_fetch_if: handshake bundle around the fetch unit.
//   Fetch bus  : inst_req_valid/inst_req_addr/inst_req_ready (request),
//                inst_rsp_valid/inst_rsp_data/inst_rsp_ready (response).
//   IF/ID side : if_pc/if_inst/if_inst_valid towards decode, if_inst_ready back.
// master = the fetch unit, slave = memory plus the IF/ID register.
interface pc_fetch_if;
  logic        inst_req_valid;
  logic [63:0] inst_req_addr;
  logic        inst_req_ready;
  logic        inst_rsp_valid;
  logic [31:0] inst_rsp_data;
  logic        inst_rsp_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        if_inst_valid;
  logic        if_inst_ready;

  modport master (
    output inst_req_valid, inst_req_addr, inst_rsp_ready,
    output if_pc, if_inst, if_inst_valid,
    input  inst_req_ready, inst_rsp_valid, inst_rsp_data, if_inst_ready
  );

  modport slave (
    input  inst_req_valid, inst_req_addr, inst_rsp_ready,
    input  if_pc, if_inst, if_inst_valid,
    output inst_req_ready, inst_rsp_valid, inst_rsp_data, if_inst_ready
  );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch front end. Owns the PC, issues one fetch at a
// time, buffers the returned instruction for IF/ID, and handles stalls and
// branch/jump redirects (including killing a fetch already in flight).
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   i_stall_ctrl global stall vector; bit 0 freezes PC advance
//   i_jump_valid redirect pulse
//   i_jump_pc    redirect target (bits [1:0] forced to 0)
//   bus          pc_fetch_if.master: fetch bus and IF/ID handshake
module pc_fetch #(
  parameter logic [63:0] START_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   i_stall_ctrl,
  input  logic         i_jump_valid,
  input  logic [63:0]  i_jump_pc,
  pc_fetch_if.master   bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      r_state;
  logic [63:0] r_pc;
  logic        r_kill;
  logic [63:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        r_if_inst_valid;

  logic [63:0] w_jump_target;
  logic [63:0] w_pc_next;
  logic        w_unused;

  assign w_jump_target = {i_jump_pc[63:2], 2'b00};
  assign w_pc_next     = r_pc + 64'(PC_STEP);  // wraps modulo 2^64
  assign w_unused      = ^{i_stall_ctrl[4:1], i_jump_pc[1:0]};

  // Bus strobes are decoded from state only: no input-to-output paths.
  assign bus.inst_req_valid = (r_state == StReq);
  assign bus.inst_req_addr  = r_pc;
  assign bus.inst_rsp_ready = (r_state == StWait);
  assign bus.if_pc          = r_if_pc;
  assign bus.if_inst        = r_if_inst;
  assign bus.if_inst_valid  = r_if_inst_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= StIdle;
      r_pc            <= START_PC;
      r_kill          <= 1'b0;
      r_if_pc         <= 64'h0;
      r_if_inst       <= 32'h0;
      r_if_inst_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: r_state <= StReq;

        StReq: begin
          if (i_jump_valid) begin
            r_pc <= w_jump_target;
            // Request for the old PC already accepted: its response is stale.
            if (bus.inst_req_ready) begin
              r_state <= StWait;
              r_kill  <= 1'b1;
            end
          end else if (bus.inst_req_ready) begin
            r_state <= StWait;
          end
        end

        StWait: begin
          if (i_jump_valid) begin
            r_pc <= w_jump_target;
          end
          if (bus.inst_rsp_valid) begin
            if (r_kill || i_jump_valid) begin
              r_kill  <= 1'b0;
              r_state <= StReq;
            end else begin
              r_if_pc         <= r_pc;
              r_if_inst       <= bus.inst_rsp_data;
              r_if_inst_valid <= 1'b1;
              r_state         <= StHold;
            end
          end else if (i_jump_valid) begin
            r_kill <= 1'b1;
          end
        end

        StHold: begin
          // Redirect wins over a simultaneous consume.
          if (i_jump_valid) begin
            r_pc            <= w_jump_target;
            r_if_inst_valid <= 1'b0;
            r_state         <= StReq;
          end else if (bus.if_inst_ready && !i_stall_ctrl[0]) begin
            r_pc            <= w_pc_next;
            r_if_inst_valid <= 1'b0;
            r_state         <= StReq;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed bench for pc_fetch with a zero-wait memory model
// (accepts every request, answers exactly one cycle later with 0x00000013).
module tb_pc_fetch;
  localparam logic [63:0] StartPc = 64'h0000_0000_8000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [4:0]  stall_ctrl;
  logic        jump_valid;
  logic [63:0] jump_pc;

  logic        mem_auto;
  logic        mem_pend;
  logic        man_rsp_valid;
  logic [31:0] man_rsp_data;

  int total;
  int bad;

  pc_fetch_if bus ();

  pc_fetch #(
    .START_PC (StartPc),
    .PC_STEP  (4)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_stall_ctrl (stall_ctrl),
    .i_jump_valid (jump_valid),
    .i_jump_pc    (jump_pc),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait memory: response exactly one cycle after acceptance.
  always @(posedge clk) mem_pend <= bus.inst_req_valid && bus.inst_req_ready;

  assign bus.inst_rsp_valid = mem_auto ? mem_pend : man_rsp_valid;
  assign bus.inst_rsp_data  = mem_auto ? Nop : man_rsp_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_valid"}, 64'(bus.inst_req_valid), 64'd0);
    chk({tag, ".req_addr"},  bus.inst_req_addr, StartPc);
    chk({tag, ".rsp_ready"}, 64'(bus.inst_rsp_ready), 64'd0);
    chk({tag, ".if_valid"},  64'(bus.if_inst_valid), 64'd0);
    chk({tag, ".if_pc"},     bus.if_pc, 64'd0);
    chk({tag, ".if_inst"},   64'(bus.if_inst), 64'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    stall_ctrl = 5'd0;
    jump_valid = 1'b0;
    jump_pc = 64'd0;
    mem_auto = 1'b1;
    mem_pend = 1'b0;
    man_rsp_valid = 1'b0;
    man_rsp_data = 32'd0;
    bus.inst_req_ready = 1'b1;
    bus.if_inst_ready = 1'b0;

    tick();
    tick();
    chk_reset_outputs("reset");

    // Reset release and first fetch.
    rst = 1'b0;
    tick();
    chk("first_req_valid", 64'(bus.inst_req_valid), 64'd1);
    chk("first_req_addr", bus.inst_req_addr, 64'h8000_0000);
    tick();
    chk("wait_rsp_ready", 64'(bus.inst_rsp_ready), 64'd1);
    chk("wait_no_req", 64'(bus.inst_req_valid), 64'd0);
    chk("wait_no_valid", 64'(bus.if_inst_valid), 64'd0);
    tick();
    chk("first_valid", 64'(bus.if_inst_valid), 64'd1);
    chk("first_if_pc", bus.if_pc, 64'h8000_0000);
    chk("first_if_inst", 64'(bus.if_inst), 64'(Nop));

    // IF/ID not ready for 5 cycles: everything holds.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 64'(bus.if_inst_valid), 64'd1);
      chk("hold_if_pc", bus.if_pc, 64'h8000_0000);
      chk("hold_no_req", 64'(bus.inst_req_valid), 64'd0);
    end

    // Stall with ready=1: still HOLD, pc unchanged.
    bus.if_inst_ready = 1'b1;
    stall_ctrl = 5'b00001;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_valid", 64'(bus.if_inst_valid), 64'd1);
      chk("stall_pc", bus.inst_req_addr, 64'h8000_0000);
      chk("stall_no_req", 64'(bus.inst_req_valid), 64'd0);
    end

    // Consume: next request at +4.
    stall_ctrl = 5'd0;
    tick();
    bus.if_inst_ready = 1'b0;
    chk("seq1_req_valid", 64'(bus.inst_req_valid), 64'd1);
    chk("seq1_req_addr", bus.inst_req_addr, 64'h8000_0004);
    chk("seq1_valid_clr", 64'(bus.if_inst_valid), 64'd0);
    chk("seq1_if_pc_kept", bus.if_pc, 64'h8000_0000);
    tick();
    tick();
    chk("seq1_if_pc", bus.if_pc, 64'h8000_0004);
    bus.if_inst_ready = 1'b1;
    tick();
    bus.if_inst_ready = 1'b0;
    chk("seq2_req_addr", bus.inst_req_addr, 64'h8000_0008);

    // Redirect while the request is accepted: response for 0x..08 is stale.
    jump_valid = 1'b1;
    jump_pc = 64'h8000_0103;
    tick();
    jump_valid = 1'b0;
    chk("kill_wait_rsp_ready", 64'(bus.inst_rsp_ready), 64'd1);
    tick();
    chk("kill_drop_valid", 64'(bus.if_inst_valid), 64'd0);
    chk("kill_req_valid", 64'(bus.inst_req_valid), 64'd1);
    chk("kill_req_addr", bus.inst_req_addr, 64'h8000_0100);
    tick();
    tick();
    chk("jmp_if_pc", bus.if_pc, 64'h8000_0100);
    chk("jmp_valid", 64'(bus.if_inst_valid), 64'd1);

    // Jump and ready in the same HOLD cycle: jump wins.
    bus.if_inst_ready = 1'b1;
    jump_valid = 1'b1;
    jump_pc = 64'h8000_0202;
    tick();
    bus.if_inst_ready = 1'b0;
    jump_valid = 1'b0;
    chk("hold_jmp_addr", bus.inst_req_addr, 64'h8000_0200);
    chk("hold_jmp_valid", 64'(bus.if_inst_valid), 64'd0);

    // Jump in WAIT coinciding with the response.
    tick();
    jump_valid = 1'b1;
    jump_pc = 64'h8000_0300;
    tick();
    jump_valid = 1'b0;
    chk("wait_jmp_req", 64'(bus.inst_req_valid), 64'd1);
    chk("wait_jmp_addr", bus.inst_req_addr, 64'h8000_0300);
    chk("wait_jmp_drop", 64'(bus.if_inst_valid), 64'd0);

    // PC wrap at the top of the address space.
    jump_valid = 1'b1;
    jump_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    jump_valid = 1'b0;
    tick();
    chk("wrap_req_addr", bus.inst_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    tick();
    chk("wrap_if_pc", bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    bus.if_inst_ready = 1'b1;
    tick();
    bus.if_inst_ready = 1'b0;
    chk("wrap_next_addr", bus.inst_req_addr, 64'd0);

    // Request not accepted for 4 cycles.
    bus.inst_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("req_stall_valid", 64'(bus.inst_req_valid), 64'd1);
      chk("req_stall_addr", bus.inst_req_addr, 64'd0);
    end
    jump_valid = 1'b1;
    jump_pc = 64'h8000_0400;
    tick();
    jump_valid = 1'b0;
    chk("req_jmp_addr", bus.inst_req_addr, 64'h8000_0400);

    // Accept, memory silent, then reset mid-WAIT.
    mem_auto = 1'b0;
    bus.inst_req_ready = 1'b1;
    tick();
    chk("pre_rst_wait", 64'(bus.inst_rsp_ready), 64'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    tick();
    rst = 1'b0;
    man_rsp_valid = 1'b1;
    man_rsp_data = 32'hDEAD_BEEF;
    chk("idle_rsp_ready", 64'(bus.inst_rsp_ready), 64'd0);
    tick();
    chk("late_rsp_ignored", 64'(bus.if_inst_valid), 64'd0);
    chk("post_rst_req", 64'(bus.inst_req_valid), 64'd1);
    chk("post_rst_addr", bus.inst_req_addr, 64'h8000_0000);
    man_rsp_valid = 1'b0;
    mem_auto = 1'b1;
    tick();
    tick();
    chk("post_rst_if_pc", bus.if_pc, 64'h8000_0000);
    chk("post_rst_if_inst", 64'(bus.if_inst), 64'(Nop));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
